// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, default weight image and FSM encoding
// for the BNN weight-load transmitter.
package bnn_pkg;

  localparam int NUM_NEURONS = 12;
  localparam int PTR_WRAP    = 16;
  localparam int IDX_W       = $clog2(PTR_WRAP) + 1;

  // Receiver reset set; entry 0 in the low byte.
  localparam logic [NUM_NEURONS-1:0][7:0] DEF_IMG = {
    8'h80, 8'h30, 8'h0C, 8'h83,
    8'h00, 8'hFF, 8'h07, 8'h0E,
    8'h1C, 8'h38, 8'h70, 8'hE0
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/bnn_weight_image.sv
// bnn_weight_image: NUM_NEURONS x 8 weight register file,
// async reset to the receiver defaults, 1 write / 1 comb read.
module bnn_weight_image
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [NUM_NEURONS-1:0][7:0] img_q;

  // Image storage; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= DEF_IMG;
    end else if (we && (waddr < 4'(NUM_NEURONS))) begin
      img_q[waddr] <= wdata;
    end
  end

  // Padding slots beyond the real image read as zero.
  always_comb begin
    rdata = 8'h00;
    if (raddr < IDX_W'(NUM_NEURONS)) begin
      rdata = img_q[raddr[3:0]];
    end
  end

endmodule

// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: serialises the weight image as nibble pairs
// plus load_en, padded so the receiver pointer wraps to 0 per stream.
module bnn_weight_streamer
  import bnn_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load_en,
  output logic [3:0] load_nibble
);

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [3:0]       gap_q, gap_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             len_q, len_n;
  logic [3:0]       nib_q, nib_n;
  logic             img_we;
  logic [7:0]       img_rd;
  logic [7:0]       rd_byte;

  assign img_we = ena && wr_en
               && (state_q == S_IDLE)
               && (wr_addr < 4'(NUM_NEURONS));

  bnn_weight_image u_img (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (img_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_n),
    .rdata (img_rd)
  );

  // A write landing on the edge that starts a stream must be seen
  // by the first nibble, so forward it past the register file.
  always_comb begin
    rd_byte = img_rd;
    if (img_we && ({1'b0, wr_addr} == idx_n)) begin
      rd_byte = wr_data;
    end
  end

  // Next-state, pair index and gap counter.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    gap_n   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_LO;
          idx_n   = '0;
        end
      end
      S_LO: state_n = S_HI;
      S_HI: begin
        idx_n = idx_q + 1'b1;
        if (idx_n == IDX_W'(PTR_WRAP)) begin
          state_n = S_DONE;
        end else if (GAP_CYCLES > 0) begin
          state_n = S_GAP;
          gap_n   = 4'(GAP_CYCLES - 1);
        end else begin
          state_n = S_LO;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_n = S_LO;
        end else begin
          gap_n = gap_q - 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output values for the cycle after the next edge.
  always_comb begin
    busy_n = state_n inside {S_LO, S_HI, S_GAP};
    done_n = (state_n == S_DONE);
    len_n  = state_n inside {S_LO, S_HI};
    nib_n  = '0;
    unique case (1'b1)
      (state_n == S_LO): nib_n = rd_byte[3:0];
      (state_n == S_HI): nib_n = rd_byte[7:4];
      default: ;
    endcase
  end

  // Control state; ena low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else if (ena) begin
      state_q <= state_n;
      idx_q   <= idx_n;
      gap_q   <= gap_n;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      len_q  <= 1'b0;
      nib_q  <= '0;
    end else if (ena) begin
      busy_q <= busy_n;
      done_q <= done_n;
      len_q  <= len_n;
      nib_q  <= nib_n;
    end
  end

  // The receiver must never see a strobe in a frozen cycle.
  assign load_en     = len_q & ena;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_nibble = nib_q;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// tb_bnn_weight_streamer: two streamers (gap 0 and gap 2) on shared
// stimulus, each paired with a receiver model and a byte scoreboard.
module tb_bnn_weight_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [1:0] le, bz, dn;
  logic [3:0] nb [2];

  int tests = 0;
  int fails = 0;

  int         gapv [2] = '{0, 2};
  logic [7:0] def_w [12] = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
                             8'hFF, 8'h00, 8'h83, 8'h0C, 8'h30, 8'h80};
  logic [7:0] img_m [2][12];
  logic [7:0] snap  [2][12];
  logic [7:0] slot  [2][16];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         ptr [2], half [2], pc [2], run [2], bcnt [2];
  logic [3:0] lo_n [2];

  always #5 clk = ~clk;

  bnn_weight_streamer #(.GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(bz[0]), .done(dn[0]), .load_en(le[0]), .load_nibble(nb[0])
  );

  bnn_weight_streamer #(.GAP_CYCLES(2)) u_g2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(bz[1]), .done(dn[1]), .load_en(le[1]), .load_nibble(nb[1])
  );

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 12; i++) img_m[k][i] = def_w[i];
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One clock of stimulus; the model accepts a write/start only when
  // that streamer is idle (not busy, no pending done) and enabled.
  task automatic step(input bit s, input bit w, input logic [3:0] a,
                      input logic [7:0] d, input bit e);
    start = s; wr_en = w; wr_addr = a; wr_data = d; ena = e;
    for (int k = 0; k < 2; k++) begin
      if (e && !bz[k] && !dn[k]) begin
        if (w && a < 12) img_m[k][a] = d;
        if (s) begin
          for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = (i < 12) ? img_m[k][i] : 8'h00;
            if (k == 0) exp_q0.push_back(v);
            else exp_q1.push_back(v);
          end
          for (int i = 0; i < 12; i++) snap[k][i] = img_m[k][i];
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0; wr_en = 1'b0; ena = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz != 2'b00 || dn != 2'b00) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 3000, "idle_timeout", n, 3000);
  endtask

  // Receiver model + scoreboard monitor.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ptr[k] = 0; half[k] = 0; pc[k] = 0; run[k] = 0; bcnt[k] = 0;
        for (int i = 0; i < 16; i++) begin
          if (i < 12) slot[k][i] = def_w[i];
          else slot[k][i] = 8'h00;
        end
      end else begin
        if (!ena) chk(le[k] == 1'b0, "ena_gate", le[k], 0);
        if (ena && bz[k] && !le[k]) run[k]++;
        if (ena && bz[k]) bcnt[k]++;
        if (le[k]) begin
          if (half[k] == 0) begin
            if (pc[k] != 0) chk(run[k] == gapv[k], "pair_gap", run[k], gapv[k]);
            run[k] = 0;
            lo_n[k] = nb[k];
            half[k] = 1;
          end else begin
            logic [7:0] got, want;
            bit empty;
            got = {nb[k], lo_n[k]};
            slot[k][ptr[k]] = got;
            ptr[k] = (ptr[k] + 1) % 16;
            half[k] = 0;
            pc[k]++;
            empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
              chk(1'b0, "pair_unexpected", got, 0);
            end else begin
              want = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk(got == want, $sformatf("pair_byte[%0d]", k), got, want);
            end
          end
        end
        if (dn[k] && ena) begin
          chk(ptr[k] == 0, "rx_ptr_wrap", ptr[k], 0);
          chk(half[k] == 0, "rx_half_pair", half[k], 0);
          chk(bcnt[k] == 32 + gapv[k] * 15, "busy_len", bcnt[k], 32 + gapv[k] * 15);
          chk((k == 0 ? exp_q0.size() : exp_q1.size()) == 0, "pairs_missing",
              (k == 0 ? exp_q0.size() : exp_q1.size()), 0);
          for (int i = 0; i < 12; i++)
            chk(slot[k][i] == snap[k][i], $sformatf("rx_slot%0d[%0d]", i, k),
                slot[k][i], snap[k][i]);
          pc[k] = 0; run[k] = 0; bcnt[k] = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation stalled");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk(le[k] == 1'b0, "rst_load_en", le[k], 0);
      chk(nb[k] == 4'h0, "rst_nibble", nb[k], 0);
      chk(bz[k] == 1'b0, "rst_busy", bz[k], 0);
      chk(dn[k] == 1'b0, "rst_done", dn[k], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Default image stream, with done timing on the gap-0 unit.
    step(1, 0, 4'd0, 8'h00, 1);
    n = 1;
    while (!dn[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n == 33, "done_at_T0+33", n, 33);
    wait_idle();

    // Real write plus an out-of-range write.
    step(0, 1, 4'd3, 8'hA5, 1);
    step(0, 1, 4'd12, 8'hFF, 1);
    step(1, 0, 4'd0, 8'h00, 1);
    wait_idle();

    // Back-to-back streams, each with a write on the start edge.
    for (int r = 0; r < 3; r++) begin
      step(1, 1, 4'($urandom_range(0, 11)), 8'($urandom), 1);
      wait_idle();
    end
    step(1, 1, 4'd0, 8'h5A, 1);
    wait_idle();

    // ena held low for 5 cycles while pair 1 high nibble is out.
    step(1, 0, 4'd0, 8'h00, 1);
    repeat (3) step(0, 0, 4'd0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'd0, 8'h00, 0);
      chk(nb[0] == img_m[0][1][7:4], "ena_hold_nibble", nb[0], img_m[0][1][7:4]);
      chk(bz[0] == 1'b1, "ena_hold_busy", bz[0], 1);
    end
    wait_idle();

    // Random streams: random ena drops, writes and starts while busy.
    for (int s = 0; s < 3; s++) begin
      repeat (3) step(0, 1, 4'($urandom_range(0, 15)), 8'($urandom), 1);
      step(1, 0, 4'd0, 8'h00, 1);
      n = 0;
      while ((bz != 2'b00 || dn != 2'b00) && n < 1500) begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             4'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 5) != 0);
        n++;
      end
      wait_idle();
    end

    // Scramble the image, then reset during pair 6.
    for (int i = 0; i < 12; i++) step(0, 1, 4'(i), 8'($urandom), 1);
    step(1, 0, 4'd0, 8'h00, 1);
    repeat (12) step(1, 0, 4'd0, 8'h00, 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(le[k] == 1'b0, "midrst_load_en", le[k], 0);
      chk(bz[k] == 1'b0, "midrst_busy", bz[k], 0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 4'd0, 8'h00, 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
